// File: rtl/fifo_pkt_reader_pkg.sv
// fifo_pkt_reader_pkg: shared state encoding and skid buffer depth
package fifo_pkt_reader_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, DRAIN = 2'd2} state_t;
  localparam int SKID_DEPTH = 2;
endpackage

// File: rtl/fifo_pkt_reader_skid_buf2.sv
// skid_buf2: 2-entry valid/ready buffer exposing its occupancy count
module skid_buf2
  import fifo_pkt_reader_pkg::*;
#(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);
  logic [W-1:0] mem [SKID_DEPTH];
  logic rd_ptr, wr_ptr, pop;
  assign out_valid = count != 2'd0;
  assign pop = out_valid && out_ready;
  assign out_data = mem[rd_ptr];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '{default: '0};
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count <= 2'd0;
    end else begin
      if (in_valid) begin
        mem[wr_ptr] <= in_data;
        wr_ptr <= !wr_ptr;
      end
      if (pop) rd_ptr <= !rd_ptr;
      count <= count + {1'b0, in_valid} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/fifo_pkt_reader.sv
// fifo_pkt_reader: drains a fifo into a sop/eop framed valid/ready packet stream
module fifo_pkt_reader
  import fifo_pkt_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 10,
  parameter int PKT_LEN    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic [ADDR_BITS-1:0]  fifo_usedw,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rdreq,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic                  busy
);
  localparam logic [ADDR_BITS-1:0] PLEN = ADDR_BITS'(PKT_LEN);
  state_t state;
  logic [ADDR_BITS-1:0] len, issued;
  logic inflight, tag_sop, tag_eop, pop;
  logic [1:0] count;
  logic [2:0] credit;
  logic [DATA_WIDTH+1:0] head;
  assign pop = out_valid && out_ready;
  assign credit = 3'(SKID_DEPTH) - {1'b0, count} - {2'b0, inflight} + {2'b0, pop};
  assign fifo_rdreq = en && state == STREAM && issued < len && !fifo_empty && credit != 3'd0;
  assign {out_sop, out_eop, out_data} = head;
  assign busy = state != IDLE;
  skid_buf2 #(.W(DATA_WIDTH + 2)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inflight),
    .in_data   ({tag_sop, tag_eop, fifo_data}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head),
    .count     (count)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      len <= '0;
      issued <= '0;
      inflight <= 1'b0;
      tag_sop <= 1'b0;
      tag_eop <= 1'b0;
    end else begin
      inflight <= fifo_rdreq;
      if (fifo_rdreq) begin
        tag_sop <= issued == '0;
        tag_eop <= issued == len - 1'b1;
        issued <= issued + 1'b1;
      end
      case (state)
        IDLE:
          if (en && fifo_usedw >= PLEN) begin
            len <= PLEN;
            issued <= '0;
            state <= STREAM;
          end else if (en && flush && fifo_usedw != '0) begin
            len <= fifo_usedw > PLEN ? PLEN : fifo_usedw;
            issued <= '0;
            state <= STREAM;
          end
        STREAM: if (issued == len) state <= DRAIN;
        DRAIN: if (pop && out_eop) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
